// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Brief    : MemOp encodings, FSM state codes and byte-enable constants
//            shared by the MEM stage and its alignment unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_HS = 3'b001;
    localparam logic [2:0] MEMOP_BS = 3'b010;
    localparam logic [2:0] MEMOP_HU = 3'b101;
    localparam logic [2:0] MEMOP_BU = 3'b110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Codes outside the defined set fall through to word accesses.
    function automatic logic is_half(input logic [2:0] op);
        return (op == MEMOP_HS) || (op == MEMOP_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return (op == MEMOP_BS) || (op == MEMOP_BU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Brief    : Combinational store lane replication / byte enables and load
//            lane select with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  i_memop,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_raw,
    output logic [3:0]  o_be,
    output logic [31:0] o_store_lanes,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unsigned;

    always_comb begin
        o_be          = BE_WORD;
        o_store_lanes = i_store_data;
        if (i_is_store) begin
            if (is_byte(i_memop)) begin
                o_be          = BE_BYTE << i_addr_lo;
                o_store_lanes = {4{i_store_data[7:0]}};
            end else if (is_half(i_memop)) begin
                o_be          = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                o_store_lanes = {2{i_store_data[15:0]}};
            end
        end
    end

    assign w_byte     = i_load_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_half     = i_load_raw[{i_addr_lo[1], 4'b0000} +: 16];
    assign w_unsigned = (i_memop == MEMOP_BU) || (i_memop == MEMOP_HU);

    always_comb begin
        o_load_data = i_load_raw;
        if (is_byte(i_memop)) begin
            o_load_data = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        end else if (is_half(i_memop)) begin
            o_load_data = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : RISC-V MEM stage: req/ready data-memory access with wait-state
//            stall, timeout abort and MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MemOp_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] ReadData2_in,
    input  logic [4:0]  rd_in,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_mem,
    output logic [4:0]  rd_MEM_WB_out,
    output logic        RegWrite_MEM_WB_out,
    output logic [31:0] WriteData_MEM_WB_out,
    output logic        misalign_MEM_WB_out,
    output logic        buserr_MEM_WB_out
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_memop;
    logic [31:0]      r_addr, r_sdata;
    logic [4:0]       r_rd;
    logic             r_we, r_regwrite, r_memtoreg;

    logic             w_access, w_misaligned, w_issue, w_waiting, w_timeout, w_complete;
    logic [2:0]       w_cur_memop;
    logic [31:0]      w_cur_addr, w_cur_sdata, w_load_data;
    logic [4:0]       w_cur_rd;
    logic             w_cur_we, w_cur_regwrite, w_cur_memtoreg;

    assign w_access     = MemRead_in | MemWrite_in;
    assign w_misaligned = is_half(MemOp_in) ? ALUResult_in[0]
                        : (!is_byte(MemOp_in) && (ALUResult_in[1:0] != 2'b00));
    assign w_waiting    = (r_state == ST_WAIT);
    assign w_issue      = (r_state == ST_IDLE) & w_access & ~w_misaligned;
    assign w_timeout    = w_waiting & ~dmem_ready & (TIMEOUT_CYCLES != 0) & (r_cnt == C_TIMEOUT);

    // While waiting the bus sees only the latched request, whatever upstream holds.
    assign w_cur_memop    = w_waiting ? r_memop    : MemOp_in;
    assign w_cur_addr     = w_waiting ? r_addr     : ALUResult_in;
    assign w_cur_sdata    = w_waiting ? r_sdata    : ReadData2_in;
    assign w_cur_we       = w_waiting ? r_we       : MemWrite_in;
    assign w_cur_rd       = w_waiting ? r_rd       : rd_in;
    assign w_cur_regwrite = w_waiting ? r_regwrite : (RegWrite_in & ~MemWrite_in);
    assign w_cur_memtoreg = w_waiting ? r_memtoreg : MemtoReg_in;

    assign dmem_req   = w_issue | w_waiting;
    assign dmem_we    = dmem_req & w_cur_we;
    assign dmem_addr  = {w_cur_addr[31:2], 2'b00};
    assign w_complete = dmem_req & dmem_ready;
    // The abort cycle releases the pipeline so the faulting op retires.
    assign stall_mem  = dmem_req & ~dmem_ready & ~w_timeout;

    mem_align u_align (
        .i_memop       (w_cur_memop),
        .i_addr_lo     (w_cur_addr[1:0]),
        .i_is_store    (w_cur_we),
        .i_store_data  (w_cur_sdata),
        .i_load_raw    (dmem_rdata),
        .o_be          (dmem_be),
        .o_store_lanes (dmem_wdata),
        .o_load_data   (w_load_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_issue && !dmem_ready) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = C_ONE;
                end
            end
            ST_WAIT: begin
                if (dmem_ready || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_memop    <= MEMOP_W;
            r_addr     <= '0;
            r_sdata    <= '0;
            r_rd       <= '0;
            r_we       <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_issue) begin
                r_memop    <= MemOp_in;
                r_addr     <= ALUResult_in;
                r_sdata    <= ReadData2_in;
                r_rd       <= rd_in;
                r_we       <= MemWrite_in;
                r_regwrite <= RegWrite_in & ~MemWrite_in;
                r_memtoreg <= MemtoReg_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_MEM_WB_out        <= '0;
            RegWrite_MEM_WB_out  <= 1'b0;
            WriteData_MEM_WB_out <= '0;
            misalign_MEM_WB_out  <= 1'b0;
            buserr_MEM_WB_out    <= 1'b0;
        end else if (w_timeout) begin
            rd_MEM_WB_out        <= r_rd;
            RegWrite_MEM_WB_out  <= 1'b0;
            WriteData_MEM_WB_out <= r_addr;
            misalign_MEM_WB_out  <= 1'b0;
            buserr_MEM_WB_out    <= 1'b1;
        end else if (stall_mem) begin
            rd_MEM_WB_out        <= '0;
            RegWrite_MEM_WB_out  <= 1'b0;
            WriteData_MEM_WB_out <= '0;
            misalign_MEM_WB_out  <= 1'b0;
            buserr_MEM_WB_out    <= 1'b0;
        end else if (w_complete) begin
            rd_MEM_WB_out        <= w_cur_rd;
            RegWrite_MEM_WB_out  <= w_cur_regwrite;
            WriteData_MEM_WB_out <= w_cur_memtoreg ? w_load_data : w_cur_addr;
            misalign_MEM_WB_out  <= 1'b0;
            buserr_MEM_WB_out    <= 1'b0;
        end else if (w_access && w_misaligned) begin
            rd_MEM_WB_out        <= rd_in;
            RegWrite_MEM_WB_out  <= 1'b0;
            WriteData_MEM_WB_out <= ALUResult_in;
            misalign_MEM_WB_out  <= 1'b1;
            buserr_MEM_WB_out    <= 1'b0;
        end else begin
            rd_MEM_WB_out        <= rd_in;
            RegWrite_MEM_WB_out  <= RegWrite_in;
            WriteData_MEM_WB_out <= ALUResult_in;
            misalign_MEM_WB_out  <= 1'b0;
            buserr_MEM_WB_out    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Scoreboard bench for mem_access_stage with directed and random
//            loads/stores against a behavioural memory-stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MemOp_in;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
    logic [31:0] ALUResult_in, ReadData2_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we, dmem_ready, stall_mem;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_o;
    logic        rw_o, mis_o, berr_o;
    logic [31:0] wd_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] wd;
        logic        mis;
        logic        berr;
        bit          ck_rd;
        bit          ck_wd;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .MemOp_in             (MemOp_in),
        .MemRead_in           (MemRead_in),
        .MemWrite_in          (MemWrite_in),
        .ALUResult_in         (ALUResult_in),
        .ReadData2_in         (ReadData2_in),
        .rd_in                (rd_in),
        .RegWrite_in          (RegWrite_in),
        .MemtoReg_in          (MemtoReg_in),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_be              (dmem_be),
        .dmem_wdata           (dmem_wdata),
        .dmem_rdata           (dmem_rdata),
        .dmem_ready           (dmem_ready),
        .stall_mem            (stall_mem),
        .rd_MEM_WB_out        (rd_o),
        .RegWrite_MEM_WB_out  (rw_o),
        .WriteData_MEM_WB_out (wd_o),
        .misalign_MEM_WB_out  (mis_o),
        .buserr_MEM_WB_out    (berr_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] op);
        case (op)
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 1;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        bit          uns;
        sh  = rdata >> (8 * addr[1:0]);
        uns = (op == 3'b101) || (op == 3'b110);
        case (size_of(op))
            1:       return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2:       return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] op, input logic [31:0] addr);
        logic [3:0] one;
        one = 4'b0001;
        case (size_of(op))
            1:       return one << addr[1:0];
            2:       return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
        case (size_of(op))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // ---------------- driver ----------------
    // k = number of cycles the memory holds ready low before asserting it.
    task automatic run_op(input logic mr, input logic mw, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic rw, input int k,
                          input logic [31:0] rdata);
        bit   access, aligned, abort;
        exp_t e;
        access  = mr | mw;
        aligned = (addr % size_of(op)) == 0;
        @(negedge clk);
        MemOp_in = op; MemRead_in = mr; MemWrite_in = mw;
        ALUResult_in = addr; ReadData2_in = sdata; rd_in = rd;
        RegWrite_in = rw; MemtoReg_in = mr & ~mw;
        if (!access || !aligned) begin
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            #1;
            chk("req_no_access", dmem_req, 0);
            chk("stall_no_access", stall_mem, 0);
            e = '{rd, access ? 1'b0 : rw, addr, access, 1'b0, 1'b1, 1'b1};
            q.push_back(e);
            return;
        end
        for (int i = 0; i <= k; i++) begin
            if (i > 0) begin
                @(negedge clk);
                MemOp_in = 3'($urandom); ALUResult_in = $urandom; ReadData2_in = $urandom;
                rd_in = 5'($urandom); RegWrite_in = 1'($urandom); MemtoReg_in = 1'($urandom);
            end
            dmem_ready = (i == k);
            dmem_rdata = (i == k) ? rdata : $urandom;
            #1;
            abort = (TO != 0) && (i == TO) && (k > TO);
            chk("req", dmem_req, 1);
            chk("we", dmem_we, mw);
            chk("addr", dmem_addr, {addr[31:2], 2'b00});
            chk("be", dmem_be, mw ? store_be(op, addr) : 4'b1111);
            if (mw) chk("wdata", dmem_wdata, store_data(op, sdata));
            chk("stall", stall_mem, (i != k) && !abort);
            if (i == k) begin
                e = '{rd, rw & ~mw, (mr & ~mw) ? load_val(op, addr, rdata) : addr,
                      1'b0, 1'b0, 1'b1, 1'b1};
                q.push_back(e);
                return;
            end else if (abort) begin
                e = '{5'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
                q.push_back(e);
                return;
            end else begin
                e = '{5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
                q.push_back(e);
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wb_regwrite", rw_o, e.rw);
                chk("wb_misalign", mis_o, e.mis);
                chk("wb_buserr", berr_o, e.berr);
                if (e.ck_rd) chk("wb_rd", rd_o, e.rd);
                if (e.ck_wd) chk("wb_wdata", wd_o, e.wd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    localparam exp_t ZERO = '{5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [31:0] a;
        logic        mr, mw, rw;
        int          kind;
        reset = 1'b1;
        MemOp_in = '0; MemRead_in = 0; MemWrite_in = 0; ALUResult_in = '0;
        ReadData2_in = '0; rd_in = '0; RegWrite_in = 0; MemtoReg_in = 0;
        dmem_rdata = '0; dmem_ready = 0;
        @(negedge clk);
        q.push_back(ZERO);
        @(posedge clk);
        #1 reset = 1'b0;

        run_op(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
        // lw zero wait
        run_op(1, 0, 3'b000, 32'h100, 32'h0, 5'd5, 1, 0, 32'hDEADBEEF);
        // lb / lbu with 2 wait cycles
        run_op(1, 0, 3'b010, 32'h103, 32'h0, 5'd6, 1, 2, 32'h80112233);
        run_op(1, 0, 3'b110, 32'h103, 32'h0, 5'd7, 1, 2, 32'h80112233);
        // sh held through 3 wait cycles
        run_op(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 0, 3, 32'h0);
        // misaligned lw
        run_op(1, 0, 3'b000, 32'h101, 32'h0, 5'd8, 1, 0, 32'h0);
        // timeout, then a non-memory op must see no request
        run_op(1, 0, 3'b000, 32'h300, 32'h0, 5'd9, 1, TO + 2, 32'h12345678);
        run_op(0, 0, 3'b000, 32'h55, 32'h0, 5'd10, 1, 0, 32'h0);

        // reset while waiting, then a late ready pulse
        @(negedge clk);
        MemOp_in = 3'b000; MemRead_in = 1; MemWrite_in = 0; ALUResult_in = 32'h400;
        rd_in = 5'd11; RegWrite_in = 1; MemtoReg_in = 1; dmem_ready = 0;
        #1 chk("rst_test_stall", stall_mem, 1);
        q.push_back('{5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        dmem_ready = 0;
        q.push_back('{5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        q.push_back(ZERO);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        MemRead_in = 0; MemWrite_in = 0; ALUResult_in = '0; rd_in = '0; RegWrite_in = 0;
        MemtoReg_in = 0; dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("post_rst_req", dmem_req, 0);
        chk("post_rst_stall", stall_mem, 0);
        q.push_back(ZERO);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            mr = (kind >= 3 && kind <= 5) || kind == 9;
            mw = kind >= 6;
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            rw = mw ? (mr ? 1'($urandom) : 1'b0) : (mr ? 1'b1 : 1'($urandom));
            run_op(mr, mw, 3'($urandom), a, $urandom, 5'($urandom), rw,
                   $urandom_range(0, TO + 2), $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
